// File: rtl/axi_spill_cut_if.sv
// AXI4+ATOP bus bundle shared by both ports of axi_spill_cut.
// The master modport drives requests and the slave modport drives responses.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_spill_cut.sv
// Full-throughput AXI register slice: one two-slot spill register per channel,
// so no combinational path crosses between the slave and master ports.
module axi_spill_cut_reg #(
  parameter int unsigned WIDTH  = 1,
  parameter bit          BYPASS = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o
);
  if (BYPASS) begin : g_bypass
    assign valid_o = valid_i;
    assign ready_o = ready_i;
    assign data_o  = data_i;
  end else begin : g_cut
    logic             a_full_q, a_full_d;
    logic             b_full_q, b_full_d;
    logic [WIDTH-1:0] a_data_q, a_data_d;
    logic [WIDTH-1:0] b_data_q, b_data_d;
    logic             push, pop;

    assign push = valid_i & ~b_full_q;
    assign pop  = a_full_q & ready_i;

    always_comb begin
      // NOTE: every _d starts at its hold value, so no branch below can infer a latch.
      a_full_d = a_full_q;
      b_full_d = b_full_q;
      a_data_d = a_data_q;
      b_data_d = b_data_q;
      unique case ({a_full_q, b_full_q})
        2'b00: if (push) begin
          a_full_d = 1'b1;
          a_data_d = data_i;
        end
        2'b10: begin
          if (push && pop) begin
            a_data_d = data_i;
          end else if (push) begin
            b_full_d = 1'b1;
            b_data_d = data_i;
          end else if (pop) begin
            a_full_d = 1'b0;
          end
        end
        2'b11: if (pop) begin
          b_full_d = 1'b0;
          a_data_d = b_data_q;
        end
        default: b_full_d = 1'b0; // spill-only state is unreachable; fall back to EMPTY
      endcase
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge _d values.
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        // NOTE: payload slots are reset too, so the sink sees all-zero fields after reset.
        a_full_q <= 1'b0;
        b_full_q <= 1'b0;
        a_data_q <= '0;
        b_data_q <= '0;
      end else begin
        a_full_q <= a_full_d;
        b_full_q <= b_full_d;
        a_data_q <= a_data_d;
        b_data_q <= b_data_d;
      end
    end

    assign valid_o = a_full_q;
    assign ready_o = ~b_full_q;
    assign data_o  = a_data_q;
  end
endmodule

module axi_spill_cut #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1,
  parameter bit          BYPASS         = 1'b0
) (
  input logic   clk_i,
  input logic   rst_ni,
  AXI_BUS.slave in,
  AXI_BUS.master out
);
  localparam int unsigned STRB_W = AXI_DATA_WIDTH / 8;
  localparam int unsigned AW_W   = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 35 + AXI_USER_WIDTH;
  localparam int unsigned AR_W   = AXI_ID_WIDTH + AXI_ADDR_WIDTH + 29 + AXI_USER_WIDTH;
  localparam int unsigned W_W    = AXI_DATA_WIDTH + STRB_W + 1 + AXI_USER_WIDTH;
  localparam int unsigned B_W    = AXI_ID_WIDTH + 2 + AXI_USER_WIDTH;
  localparam int unsigned R_W    = AXI_ID_WIDTH + AXI_DATA_WIDTH + 3 + AXI_USER_WIDTH;

  logic [AW_W-1:0] aw_src, aw_snk;
  logic [W_W-1:0]  w_src, w_snk;
  logic [B_W-1:0]  b_src, b_snk;
  logic [AR_W-1:0] ar_src, ar_snk;
  logic [R_W-1:0]  r_src, r_snk;

  // Requests flow in -> out
  assign aw_src = {in.aw_id, in.aw_addr, in.aw_len, in.aw_size, in.aw_burst, in.aw_lock,
                   in.aw_cache, in.aw_prot, in.aw_qos, in.aw_region, in.aw_atop, in.aw_user};
  assign {out.aw_id, out.aw_addr, out.aw_len, out.aw_size, out.aw_burst, out.aw_lock,
          out.aw_cache, out.aw_prot, out.aw_qos, out.aw_region, out.aw_atop,
          out.aw_user} = aw_snk;

  assign w_src = {in.w_data, in.w_strb, in.w_last, in.w_user};
  assign {out.w_data, out.w_strb, out.w_last, out.w_user} = w_snk;

  assign ar_src = {in.ar_id, in.ar_addr, in.ar_len, in.ar_size, in.ar_burst, in.ar_lock,
                   in.ar_cache, in.ar_prot, in.ar_qos, in.ar_region, in.ar_user};
  assign {out.ar_id, out.ar_addr, out.ar_len, out.ar_size, out.ar_burst, out.ar_lock,
          out.ar_cache, out.ar_prot, out.ar_qos, out.ar_region, out.ar_user} = ar_snk;

  // Responses flow out -> in
  assign b_src = {out.b_id, out.b_resp, out.b_user};
  assign {in.b_id, in.b_resp, in.b_user} = b_snk;

  assign r_src = {out.r_id, out.r_data, out.r_resp, out.r_last, out.r_user};
  assign {in.r_id, in.r_data, in.r_resp, in.r_last, in.r_user} = r_snk;

  axi_spill_cut_reg #(.WIDTH(AW_W), .BYPASS(BYPASS)) i_aw (
    .clk_i, .rst_ni,
    .valid_i(in.aw_valid),  .ready_o(in.aw_ready),  .data_i(aw_src),
    .valid_o(out.aw_valid), .ready_i(out.aw_ready), .data_o(aw_snk)
  );

  axi_spill_cut_reg #(.WIDTH(W_W), .BYPASS(BYPASS)) i_w (
    .clk_i, .rst_ni,
    .valid_i(in.w_valid),  .ready_o(in.w_ready),  .data_i(w_src),
    .valid_o(out.w_valid), .ready_i(out.w_ready), .data_o(w_snk)
  );

  axi_spill_cut_reg #(.WIDTH(AR_W), .BYPASS(BYPASS)) i_ar (
    .clk_i, .rst_ni,
    .valid_i(in.ar_valid),  .ready_o(in.ar_ready),  .data_i(ar_src),
    .valid_o(out.ar_valid), .ready_i(out.ar_ready), .data_o(ar_snk)
  );

  axi_spill_cut_reg #(.WIDTH(B_W), .BYPASS(BYPASS)) i_b (
    .clk_i, .rst_ni,
    .valid_i(out.b_valid), .ready_o(out.b_ready), .data_i(b_src),
    .valid_o(in.b_valid),  .ready_i(in.b_ready),  .data_o(b_snk)
  );

  axi_spill_cut_reg #(.WIDTH(R_W), .BYPASS(BYPASS)) i_r (
    .clk_i, .rst_ni,
    .valid_i(out.r_valid), .ready_o(out.r_ready), .data_i(r_src),
    .valid_o(in.r_valid),  .ready_i(in.r_ready),  .data_o(r_snk)
  );
endmodule

// File: tb/tb_axi_spill_cut.sv
// Directed bench for axi_spill_cut: per-channel scoreboards fed at source handshakes
// and drained at sink handshakes, plus a BYPASS=1 pass-through instance.
module tb_axi_spill_cut;
  localparam int unsigned AW_W = 4 + 64 + 35 + 1;
  localparam int unsigned AR_W = 4 + 64 + 29 + 1;
  localparam int unsigned W_W  = 64 + 8 + 1 + 1;
  localparam int unsigned B_W  = 4 + 2 + 1;
  localparam int unsigned R_W  = 4 + 64 + 3 + 1;

  logic clk = 1'b0;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  AXI_BUS in_bus ();
  AXI_BUS out_bus ();
  AXI_BUS byp_in ();
  AXI_BUS byp_out ();

  axi_spill_cut #(.BYPASS(1'b0)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in(in_bus), .out(out_bus)
  );

  axi_spill_cut #(.BYPASS(1'b1)) dut_byp (
    .clk_i(clk), .rst_ni(rst_n), .in(byp_in), .out(byp_out)
  );

  logic [AW_W-1:0] aw_src, aw_snk;
  logic [W_W-1:0]  w_src, w_snk;
  logic [AR_W-1:0] ar_src, ar_snk;
  logic [B_W-1:0]  b_src, b_snk;
  logic [R_W-1:0]  r_src, r_snk;

  assign aw_src = {in_bus.aw_id, in_bus.aw_addr, in_bus.aw_len, in_bus.aw_size, in_bus.aw_burst,
                   in_bus.aw_lock, in_bus.aw_cache, in_bus.aw_prot, in_bus.aw_qos,
                   in_bus.aw_region, in_bus.aw_atop, in_bus.aw_user};
  assign aw_snk = {out_bus.aw_id, out_bus.aw_addr, out_bus.aw_len, out_bus.aw_size,
                   out_bus.aw_burst, out_bus.aw_lock, out_bus.aw_cache, out_bus.aw_prot,
                   out_bus.aw_qos, out_bus.aw_region, out_bus.aw_atop, out_bus.aw_user};
  assign w_src  = {in_bus.w_data, in_bus.w_strb, in_bus.w_last, in_bus.w_user};
  assign w_snk  = {out_bus.w_data, out_bus.w_strb, out_bus.w_last, out_bus.w_user};
  assign ar_src = {in_bus.ar_id, in_bus.ar_addr, in_bus.ar_len, in_bus.ar_size, in_bus.ar_burst,
                   in_bus.ar_lock, in_bus.ar_cache, in_bus.ar_prot, in_bus.ar_qos,
                   in_bus.ar_region, in_bus.ar_user};
  assign ar_snk = {out_bus.ar_id, out_bus.ar_addr, out_bus.ar_len, out_bus.ar_size,
                   out_bus.ar_burst, out_bus.ar_lock, out_bus.ar_cache, out_bus.ar_prot,
                   out_bus.ar_qos, out_bus.ar_region, out_bus.ar_user};
  assign b_src  = {out_bus.b_id, out_bus.b_resp, out_bus.b_user};
  assign b_snk  = {in_bus.b_id, in_bus.b_resp, in_bus.b_user};
  assign r_src  = {out_bus.r_id, out_bus.r_data, out_bus.r_resp, out_bus.r_last, out_bus.r_user};
  assign r_snk  = {in_bus.r_id, in_bus.r_data, in_bus.r_resp, in_bus.r_last, in_bus.r_user};

  logic [AW_W-1:0] aw_q[$];
  logic [W_W-1:0]  w_q[$];
  logic [AR_W-1:0] ar_q[$];
  logic [B_W-1:0]  b_q[$];
  logic [R_W-1:0]  r_q[$];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshakes are decided by the values stable at the falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_bus.aw_valid && out_bus.aw_ready) begin
        check("aw_sb_nonempty", 512'(aw_q.size() != 0), 512'(1));
        if (aw_q.size() != 0) check("aw_beat", 512'(aw_snk), 512'(aw_q.pop_front()));
      end
      if (in_bus.aw_valid && in_bus.aw_ready) aw_q.push_back(aw_src);
      if (out_bus.w_valid && out_bus.w_ready) begin
        check("w_sb_nonempty", 512'(w_q.size() != 0), 512'(1));
        if (w_q.size() != 0) check("w_beat", 512'(w_snk), 512'(w_q.pop_front()));
      end
      if (in_bus.w_valid && in_bus.w_ready) w_q.push_back(w_src);
      if (out_bus.ar_valid && out_bus.ar_ready) begin
        check("ar_sb_nonempty", 512'(ar_q.size() != 0), 512'(1));
        if (ar_q.size() != 0) check("ar_beat", 512'(ar_snk), 512'(ar_q.pop_front()));
      end
      if (in_bus.ar_valid && in_bus.ar_ready) ar_q.push_back(ar_src);
      if (in_bus.b_valid && in_bus.b_ready) begin
        check("b_sb_nonempty", 512'(b_q.size() != 0), 512'(1));
        if (b_q.size() != 0) check("b_beat", 512'(b_snk), 512'(b_q.pop_front()));
      end
      if (out_bus.b_valid && out_bus.b_ready) b_q.push_back(b_src);
      if (in_bus.r_valid && in_bus.r_ready) begin
        check("r_sb_nonempty", 512'(r_q.size() != 0), 512'(1));
        if (r_q.size() != 0) check("r_beat", 512'(r_snk), 512'(r_q.pop_front()));
      end
      if (out_bus.r_valid && out_bus.r_ready) r_q.push_back(r_src);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cut();
    in_bus.aw_id = '0;   in_bus.aw_addr = '0;  in_bus.aw_len = '0;   in_bus.aw_size = '0;
    in_bus.aw_burst = '0; in_bus.aw_lock = '0; in_bus.aw_cache = '0; in_bus.aw_prot = '0;
    in_bus.aw_qos = '0;  in_bus.aw_region = '0; in_bus.aw_atop = '0; in_bus.aw_user = '0;
    in_bus.aw_valid = 1'b0;
    in_bus.w_data = '0;  in_bus.w_strb = '0;   in_bus.w_last = 1'b0; in_bus.w_user = '0;
    in_bus.w_valid = 1'b0;
    in_bus.ar_id = '0;   in_bus.ar_addr = '0;  in_bus.ar_len = '0;   in_bus.ar_size = '0;
    in_bus.ar_burst = '0; in_bus.ar_lock = '0; in_bus.ar_cache = '0; in_bus.ar_prot = '0;
    in_bus.ar_qos = '0;  in_bus.ar_region = '0; in_bus.ar_user = '0;
    in_bus.ar_valid = 1'b0;
    in_bus.b_ready = 1'b1; in_bus.r_ready = 1'b1;
    out_bus.aw_ready = 1'b1; out_bus.w_ready = 1'b1; out_bus.ar_ready = 1'b1;
    out_bus.b_id = '0; out_bus.b_resp = '0; out_bus.b_user = '0; out_bus.b_valid = 1'b0;
    out_bus.r_id = '0; out_bus.r_data = '0; out_bus.r_resp = '0; out_bus.r_last = 1'b0;
    out_bus.r_user = '0; out_bus.r_valid = 1'b0;
  endtask

  task automatic randomize_bypass();
    byp_in.aw_id = 4'($urandom);   byp_in.aw_addr = {$urandom, $urandom};
    byp_in.aw_len = 8'($urandom);  byp_in.aw_size = 3'($urandom); byp_in.aw_burst = 2'($urandom);
    byp_in.aw_lock = 1'($urandom); byp_in.aw_cache = 4'($urandom); byp_in.aw_prot = 3'($urandom);
    byp_in.aw_qos = 4'($urandom);  byp_in.aw_region = 4'($urandom); byp_in.aw_atop = 6'($urandom);
    byp_in.aw_user = 1'($urandom); byp_in.aw_valid = 1'($urandom);
    byp_in.w_data = {$urandom, $urandom}; byp_in.w_strb = 8'($urandom);
    byp_in.w_last = 1'($urandom);  byp_in.w_user = 1'($urandom); byp_in.w_valid = 1'($urandom);
    byp_in.ar_id = 4'($urandom);   byp_in.ar_addr = {$urandom, $urandom};
    byp_in.ar_len = 8'($urandom);  byp_in.ar_size = 3'($urandom); byp_in.ar_burst = 2'($urandom);
    byp_in.ar_lock = 1'($urandom); byp_in.ar_cache = 4'($urandom); byp_in.ar_prot = 3'($urandom);
    byp_in.ar_qos = 4'($urandom);  byp_in.ar_region = 4'($urandom); byp_in.ar_user = 1'($urandom);
    byp_in.ar_valid = 1'($urandom);
    byp_in.b_ready = 1'($urandom); byp_in.r_ready = 1'($urandom);
    byp_out.aw_ready = 1'($urandom); byp_out.w_ready = 1'($urandom);
    byp_out.ar_ready = 1'($urandom);
    byp_out.b_id = 4'($urandom); byp_out.b_resp = 2'($urandom); byp_out.b_user = 1'($urandom);
    byp_out.b_valid = 1'($urandom);
    byp_out.r_id = 4'($urandom); byp_out.r_data = {$urandom, $urandom};
    byp_out.r_resp = 2'($urandom); byp_out.r_last = 1'($urandom); byp_out.r_user = 1'($urandom);
    byp_out.r_valid = 1'($urandom);
  endtask

  initial begin
    int  r_idx;
    logic r_hs;

    // Reset with a request pending on AW
    idle_cut();
    rst_n = 1'b0;
    in_bus.aw_valid = 1'b1;
    in_bus.aw_id = 4'd5;
    in_bus.aw_addr = 64'hdead_beef;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_valids", 512'({out_bus.aw_valid, out_bus.w_valid, out_bus.ar_valid,
                                in_bus.b_valid, in_bus.r_valid}), 512'(5'b00000));
      check("rst_readys", 512'({in_bus.aw_ready, in_bus.w_ready, in_bus.ar_ready,
                                out_bus.b_ready, out_bus.r_ready}), 512'(5'b11111));
      check("rst_payload", 512'({aw_snk, r_snk, b_snk}), 512'(0));
    end
    next_cycle();
    in_bus.aw_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("rst_no_accept", 512'(out_bus.aw_valid), 512'(0));
      next_cycle();
    end

    // Single AW beat
    in_bus.aw_valid = 1'b1;
    in_bus.aw_id = 4'd3;
    in_bus.aw_addr = 64'h1000;
    in_bus.aw_len = 8'd7;
    in_bus.aw_size = 3'd3;
    in_bus.aw_burst = 2'd1;
    @(negedge clk);
    check("aw_ready", 512'(in_bus.aw_ready), 512'(1));
    next_cycle();
    in_bus.aw_valid = 1'b0;
    @(negedge clk);
    check("aw_valid_lat1", 512'(out_bus.aw_valid), 512'(1));
    check("aw_fields", 512'({out_bus.aw_id, out_bus.aw_addr, out_bus.aw_len}),
          512'({4'd3, 64'h1000, 8'd7}));
    next_cycle();
    @(negedge clk);
    check("aw_valid_drop", 512'(out_bus.aw_valid), 512'(0));

    // Streaming W, 16 beats back to back
    for (int i = 0; i <= 16; i++) begin
      next_cycle();
      in_bus.w_valid = (i < 16);
      in_bus.w_data = 64'(i);
      in_bus.w_strb = 8'hff;
      in_bus.w_last = (i == 15);
      @(negedge clk);
      if (i < 16) check("w_ready_high", 512'(in_bus.w_ready), 512'(1));
      check("w_out_valid", 512'(out_bus.w_valid), 512'(i != 0));
      if (i != 0) begin
        check("w_out_data", 512'(out_bus.w_data), 512'(i - 1));
        check("w_out_last", 512'(out_bus.w_last), 512'(i == 16));
      end
    end
    next_cycle();
    in_bus.w_valid = 1'b0;
    @(negedge clk);
    check("w_out_idle", 512'(out_bus.w_valid), 512'(0));

    // R backpressure: sink stalled for the first 5 cycles
    r_idx = 0;
    r_hs = 1'b0;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      if (r_hs) r_idx++;
      in_bus.r_ready = (c >= 5);
      out_bus.r_valid = (r_idx < 4);
      out_bus.r_data = 64'hA0 + 64'(r_idx);
      out_bus.r_id = 4'(r_idx);
      out_bus.r_last = (r_idx == 3);
      @(negedge clk);
      r_hs = out_bus.r_valid && out_bus.r_ready;
      check("r_src_ready", 512'(out_bus.r_ready), 512'(!(c >= 2 && c <= 5)));
      if (c >= 1 && c <= 5) begin
        check("r_stall_valid", 512'(in_bus.r_valid), 512'(1));
        check("r_stall_data", 512'(in_bus.r_data), 512'(64'hA0));
      end
    end
    check("r_all_accepted", 512'(r_idx), 512'(4));
    check("r_all_delivered", 512'(r_q.size()), 512'(0));

    // B stalled while AR streams
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      in_bus.b_ready = (c >= 9);
      out_bus.b_valid = (c < 2);
      out_bus.b_id = 4'(c + 1);
      out_bus.b_resp = 2'(c);
      in_bus.ar_valid = (c < 8);
      in_bus.ar_id = 4'(c);
      in_bus.ar_addr = 64'h2000 + 64'(c);
      @(negedge clk);
      if (c < 8) check("ar_ready_high", 512'(in_bus.ar_ready), 512'(1));
      if (c >= 1 && c <= 8) begin
        check("ar_out_valid", 512'(out_bus.ar_valid), 512'(1));
        check("ar_out_addr", 512'(out_bus.ar_addr), 512'(64'h2000 + 64'(c - 1)));
        check("b_held_valid", 512'(in_bus.b_valid), 512'(1));
      end
      check("b_src_ready", 512'(out_bus.b_ready), 512'(!(c >= 2 && c <= 9)));
    end
    check("ar_all_delivered", 512'(ar_q.size()), 512'(0));
    check("b_all_delivered", 512'(b_q.size()), 512'(0));
    check("aw_all_delivered", 512'(aw_q.size()), 512'(0));
    check("w_all_delivered", 512'(w_q.size()), 512'(0));

    // BYPASS instance: pure wires
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      randomize_bypass();
      #1;
      check("byp_aw", 512'({byp_out.aw_id, byp_out.aw_addr, byp_out.aw_len, byp_out.aw_size,
                            byp_out.aw_burst, byp_out.aw_lock, byp_out.aw_cache, byp_out.aw_prot,
                            byp_out.aw_qos, byp_out.aw_region, byp_out.aw_atop, byp_out.aw_user,
                            byp_out.aw_valid}),
            512'({byp_in.aw_id, byp_in.aw_addr, byp_in.aw_len, byp_in.aw_size,
                  byp_in.aw_burst, byp_in.aw_lock, byp_in.aw_cache, byp_in.aw_prot,
                  byp_in.aw_qos, byp_in.aw_region, byp_in.aw_atop, byp_in.aw_user,
                  byp_in.aw_valid}));
      check("byp_w", 512'({byp_out.w_data, byp_out.w_strb, byp_out.w_last, byp_out.w_user,
                           byp_out.w_valid}),
            512'({byp_in.w_data, byp_in.w_strb, byp_in.w_last, byp_in.w_user, byp_in.w_valid}));
      check("byp_ar", 512'({byp_out.ar_id, byp_out.ar_addr, byp_out.ar_len, byp_out.ar_size,
                            byp_out.ar_burst, byp_out.ar_lock, byp_out.ar_cache, byp_out.ar_prot,
                            byp_out.ar_qos, byp_out.ar_region, byp_out.ar_user,
                            byp_out.ar_valid}),
            512'({byp_in.ar_id, byp_in.ar_addr, byp_in.ar_len, byp_in.ar_size,
                  byp_in.ar_burst, byp_in.ar_lock, byp_in.ar_cache, byp_in.ar_prot,
                  byp_in.ar_qos, byp_in.ar_region, byp_in.ar_user, byp_in.ar_valid}));
      check("byp_b", 512'({byp_in.b_id, byp_in.b_resp, byp_in.b_user, byp_in.b_valid}),
            512'({byp_out.b_id, byp_out.b_resp, byp_out.b_user, byp_out.b_valid}));
      check("byp_r", 512'({byp_in.r_id, byp_in.r_data, byp_in.r_resp, byp_in.r_last,
                           byp_in.r_user, byp_in.r_valid}),
            512'({byp_out.r_id, byp_out.r_data, byp_out.r_resp, byp_out.r_last,
                  byp_out.r_user, byp_out.r_valid}));
      check("byp_ready", 512'({byp_in.aw_ready, byp_in.w_ready, byp_in.ar_ready,
                               byp_out.b_ready, byp_out.r_ready}),
            512'({byp_out.aw_ready, byp_out.w_ready, byp_out.ar_ready,
                  byp_in.b_ready, byp_in.r_ready}));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
